// File: rtl/rv32imf_pkg.sv
// rtl/rv32imf_pkg.sv - shared types and helpers for the sequential multiplier
package rv32imf_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mult_seq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_seq_state_e;

    // op_a is treated as signed for MULH and MULHSU
    function automatic logic a_is_signed(mult_seq_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    // op_b is treated as signed for MULH only
    function automatic logic b_is_signed(mult_seq_op_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/rv32imf_mult_seq_if.sv
// rtl/rv32imf_mult_seq_if.sv - request/result bundle of the sequential multiplier
// Request side : valid_i/ready_o handshake, op_i, acc_i, op_a_i/op_b_i/op_c_i, kill_i.
// Result side  : valid_o/ready_i handshake, result_o; busy_o status.
interface rv32imf_mult_seq_if #(
    parameter int XLEN = 32
) ();
    import rv32imf_pkg::*;

    logic             valid_i;
    logic             ready_o;
    mult_seq_op_e     op_i;
    logic             acc_i;
    logic [XLEN-1:0]  op_a_i;
    logic [XLEN-1:0]  op_b_i;
    logic [XLEN-1:0]  op_c_i;
    logic             kill_i;
    logic [XLEN-1:0]  result_o;
    logic             valid_o;
    logic             ready_i;
    logic             busy_o;

    modport slave (
        input  valid_i, op_i, acc_i, op_a_i, op_b_i, op_c_i, kill_i, ready_i,
        output ready_o, result_o, valid_o, busy_o
    );

    modport master (
        output valid_i, op_i, acc_i, op_a_i, op_b_i, op_c_i, kill_i, ready_i,
        input  ready_o, result_o, valid_o, busy_o
    );

endinterface

// File: rtl/rv32imf_mult_seq_pp.sv
// rtl/rv32imf_mult_seq_pp.sv - combinational signed partial-product multiplier
// a : XLEN+1 bit signed operand (already sign/zero extended)
// b : CHUNK+1 bit signed chunk of the second operand
// p : exact signed product, XLEN+CHUNK+2 bits
module rv32imf_mult_seq_pp #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 16
) (
    input  logic signed [XLEN:0]         a,
    input  logic signed [CHUNK:0]        b,
    output logic signed [XLEN+CHUNK+1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/rv32imf_mult_seq.sv
// rtl/rv32imf_mult_seq.sv - iterative MUL/MULH/MULHSU/MULHU unit, CHUNK bits of op_b per cycle
// clk, rst : clock and asynchronous active-high reset
// bus      : slave side of rv32imf_mult_seq_if (request, result and status signals)
module rv32imf_mult_seq
    import rv32imf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 16
) (
    input logic               clk,
    input logic               rst,
    rv32imf_mult_seq_if.slave bus
);

    localparam int N      = XLEN / CHUNK;
    localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
    localparam int AW     = 2 * XLEN + 2;
    localparam int PW     = XLEN + CHUNK + 2;
    localparam logic [STEP_W-1:0] LAST = STEP_W'(N - 1);

    if (XLEN % CHUNK != 0) begin : g_chunk_check
        $error("CHUNK must divide XLEN");
    end

    mult_seq_state_e      state;
    logic [STEP_W-1:0]    step;
    logic [AW-1:0]        acc;
    logic [XLEN:0]        a_lat;
    logic [XLEN:0]        b_lat;
    logic [XLEN-1:0]      c_lat;
    mult_seq_op_e         op_lat;
    logic                 add_c;

    logic                 ready;
    logic                 accept;
    logic                 zero_op;
    logic                 last_step;
    logic [CHUNK:0]       b_chunk;
    logic signed [PW-1:0] pp;
    logic signed [AW-1:0] pp_ext;
    logic [AW-1:0]        pp_shift;
    logic [XLEN-1:0]      result;
    logic                 acc_unused;

    assign ready     = (state == ST_IDLE) && !bus.kill_i;
    assign accept    = bus.valid_i && ready;
    assign zero_op   = (a_lat[XLEN-1:0] == '0) || (b_lat[XLEN-1:0] == '0);
    assign last_step = (step == LAST);

    // Lower chunks are unsigned digits; only the top chunk carries b's extension bit.
    always_comb begin
        b_chunk = {1'b0, b_lat[int'(step)*CHUNK +: CHUNK]};
        if (last_step) begin
            b_chunk[CHUNK] = b_lat[XLEN];
        end
    end

    rv32imf_mult_seq_pp #(
        .XLEN  (XLEN),
        .CHUNK (CHUNK)
    ) u_pp (
        .a (a_lat),
        .b (b_chunk),
        .p (pp)
    );

    // Sign-extend to accumulator width, then weight by the chunk position.
    assign pp_ext   = AW'(pp);
    assign pp_shift = pp_ext << (int'(step) * CHUNK);

    // Top two accumulator bits only absorb the extension of the exact product.
    assign acc_unused = ^acc[AW-1:2*XLEN];

    always_comb begin
        result = '0;
        if (state == ST_DONE) begin
            if (op_lat == OP_MUL) begin
                result = acc[XLEN-1:0] + (add_c ? c_lat : '0);
            end else begin
                result = acc[2*XLEN-1:XLEN];
            end
        end
    end

    assign bus.ready_o  = ready;
    assign bus.valid_o  = (state == ST_DONE);
    assign bus.busy_o   = (state != ST_IDLE);
    assign bus.result_o = result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            step   <= '0;
            acc    <= '0;
            a_lat  <= '0;
            b_lat  <= '0;
            c_lat  <= '0;
            op_lat <= OP_MUL;
            add_c  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_lat <= bus.op_i;
                        add_c  <= bus.acc_i && (bus.op_i == OP_MUL);
                        a_lat  <= {a_is_signed(bus.op_i) & bus.op_a_i[XLEN-1], bus.op_a_i};
                        b_lat  <= {b_is_signed(bus.op_i) & bus.op_b_i[XLEN-1], bus.op_b_i};
                        c_lat  <= bus.op_c_i;
                        acc    <= '0;
                        step   <= '0;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (bus.kill_i) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc + pp_shift;
                        // A zero operand makes every partial product zero: finish now.
                        if (zero_op || last_step) begin
                            state <= ST_DONE;
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.kill_i || bus.ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rv32imf_mult_seq.md
RV32IMF_MULT_SEQ -- requirements
Module: rv32imf_mult_seq

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 Parameter CHUNK, default 16: op_b bits consumed per step; XLEN % CHUNK == 0 SHALL hold (elaboration error otherwise); N = XLEN/CHUNK.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 valid_i  in  1  request valid.
REQ-006 ready_o  out  1  request accepted when valid_i & ready_o at a rising edge.
REQ-007 op_i  in  2  mult_seq_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3.
REQ-008 acc_i  in  1  MUL only: add op_c_i to low product.
REQ-009 op_a_i, op_b_i, op_c_i  in  XLEN each  operands.
REQ-010 kill_i  in  1  abort current operation.
REQ-011 result_o  out  XLEN  result, held stable while valid_o & ~ready_i.
REQ-012 valid_o  out  1  result valid.
REQ-013 ready_i  in  1  downstream ready; result consumed on valid_o & ready_i.
REQ-014 busy_o  out  1  high in CALC and DONE.

Function
REQ-015 FSM states IDLE, CALC, DONE (mult_seq_state_e); ready_o = (state == IDLE) & ~kill_i.
REQ-016 IDLE -> CALC on accept; operands, op, acc latched; step counter cleared to 0.
REQ-017 Operand signedness: a signed for MULH/MULHSU, b signed for MULH only; both extended to XLEN+1 bits.
REQ-018 Each CALC cycle: (XLEN+1) x (CHUNK+1) signed partial product of latched a and chunk[step] of b (only chunk N-1 carries b's sign bit, others zero-extended), added into a 2*XLEN+2 bit accumulator at offset step*CHUNK.
REQ-019 CALC -> DONE after step N-1 completes; valid_o first high N cycles after the accepting edge.
REQ-020 Result: MUL = product[XLEN-1:0] (+ op_c_i modulo 2^XLEN if acc_i); MULH/MULHSU/MULHU = product[2*XLEN-1:XLEN]; product exact two's-complement.
REQ-021 Early-out: latched a == 0 or b == 0 -> CALC -> DONE after one cycle, result 0 (or op_c_i for MUL with acc_i).
REQ-022 DONE -> IDLE on ready_i; no new request accepted in the same cycle (one bubble).
REQ-023 DONE with ready_i low: state, result_o, valid_o held indefinitely.
REQ-024 kill_i in CALC or DONE: next state IDLE, valid_o low next cycle, result discarded; kill_i has priority over ready_i.
REQ-025 kill_i with valid_i in IDLE: request not accepted.
REQ-026 acc_i ignored for op_i != MUL.
REQ-027 result_o = 0 whenever valid_o low.

Reset
REQ-028 rst asserted: state IDLE, step counter 0, accumulator 0, latched operands 0, valid_o 0, busy_o 0, result_o 0, ready_o 1 after release.
REQ-029 rst mid-operation: operation lost, no valid_o after release.

Structure
REQ-030 mult_seq_op_e and mult_seq_state_e SHALL live in rv32imf_pkg.
REQ-031 Partial-product multiplier SHALL be sub-module rv32imf_mult_seq_pp (parameters XLEN, CHUNK; purely combinational).
REQ-032 No multiplier wider than (XLEN+1) x (CHUNK+1) SHALL be inferred.

Verification (XLEN=32, CHUNK=16 unless stated)
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, valid_o exactly 2 cycles after accept.
REQ-034 MULH 0x80000000 x 0x80000000 -> 0x40000000; MUL same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 MUL acc_i=1, a=3, b=5, c=7 -> 22; MUL a=0, b=0x1234, acc_i=0 -> 0 with valid_o 1 cycle after accept.
REQ-036 ready_i low 3 cycles in DONE -> result_o/valid_o stable; ready_i high -> IDLE, ready_o high next cycle.
REQ-037 kill_i in first CALC cycle -> no valid_o, ready_o high next cycle; rst pulse in CALC -> same, all outputs at reset values.
REQ-038 CHUNK=8 (N=4): MULH 0xFFFFFFFE x 0x00000003 -> 0xFFFFFFFF, latency 4; 10k random ops vs reference model, all ops.
